// File: rtl/mem_sched_pkg.sv
// mem_sched shared types and defaults.
// State encoding and default DRAM geometry.
package mem_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    H_ACC = 2'd1,
    RUN   = 2'd2,
    P_ACC = 2'd3
  } state_t;

  localparam int ADDR_W_DEF  = 16;
  localparam int DATA_W_DEF  = 8;
  localparam int MEM_LAT_DEF = 2;

endpackage

// File: rtl/mem_access_engine.sv
// Fixed-latency DRAM access engine.
// One request in flight; result and ack routed back to its requester.
module mem_access_engine
  import mem_sched_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int MEM_LAT = MEM_LAT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              src,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              host_ack,
  output logic [DATA_W-1:0] host_rdata,
  output logic              proc_ack,
  output logic [DATA_W-1:0] proc_rdata
);

  localparam int CW = $clog2(MEM_LAT + 1);

  logic          src_q;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      src_q      <= 1'b0;
      cnt        <= '0;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      host_ack   <= 1'b0;
      host_rdata <= '0;
      proc_ack   <= 1'b0;
      proc_rdata <= '0;
    end else begin
      mem_en   <= start;
      host_ack <= 1'b0;
      proc_ack <= 1'b0;
      if (start) begin
        src_q     <= src;
        mem_we    <= we;
        mem_addr  <= addr;
        mem_wdata <= wdata;
      end
      // latency is counted from the edge that ends the strobe cycle
      if (mem_en) begin
        cnt <= CW'(MEM_LAT);
      end else if (cnt != '0) begin
        cnt <= cnt - CW'(1);
        if (cnt == CW'(1)) begin
          if (src_q) begin
            proc_ack <= 1'b1;
            if (!mem_we) proc_rdata <= mem_rdata;
          end else begin
            host_ack <= 1'b1;
            if (!mem_we) host_rdata <= mem_rdata;
          end
        end
      end
    end
  end

endmodule

// File: rtl/mem_sched.sv
// System sequencer and DRAM ownership arbiter.
// Host owns DRAM while idle; a start hands it to the processor.
module mem_sched
  import mem_sched_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int MEM_LAT = MEM_LAT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              host_start,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_ack,
  output logic [DATA_W-1:0] host_rdata,
  output logic              done,
  output logic              proc_enable,
  input  logic              proc_finish,
  input  logic              proc_read,
  input  logic              proc_write,
  input  logic [ADDR_W-1:0] proc_addr,
  input  logic [DATA_W-1:0] proc_wdata,
  output logic              proc_ack,
  output logic [DATA_W-1:0] proc_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  state_t            state, state_n;
  logic              start_pend, start_pend_n;
  logic              done_n;
  logic              go, go_src, go_we;
  logic [ADDR_W-1:0] go_addr;
  logic [DATA_W-1:0] go_wdata;

  always_comb begin
    state_n      = state;
    start_pend_n = start_pend;
    done_n       = done;
    go           = 1'b0;
    go_src       = 1'b0;
    go_we        = host_we;
    go_addr      = host_addr;
    go_wdata     = host_wdata;
    unique case (state)
      IDLE: begin
        if (host_req) begin
          state_n      = H_ACC;
          go           = 1'b1;
          start_pend_n = host_start;
        end else if (host_start) begin
          state_n = RUN;
          done_n  = 1'b0;
        end
      end
      H_ACC: begin
        if (host_ack) begin
          if (start_pend) begin
            state_n      = RUN;
            start_pend_n = 1'b0;
            done_n       = 1'b0;
          end else begin
            state_n = IDLE;
          end
        end
      end
      RUN: begin
        go_src   = 1'b1;
        go_we    = proc_write;
        go_addr  = proc_addr;
        go_wdata = proc_wdata;
        // finish beats a same-cycle strobe
        if (proc_finish) begin
          state_n = IDLE;
          done_n  = 1'b1;
        end else if (proc_read || proc_write) begin
          state_n = P_ACC;
          go      = 1'b1;
        end
      end
      P_ACC: begin
        if (proc_ack) state_n = RUN;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      start_pend  <= 1'b0;
      done        <= 1'b0;
      proc_enable <= 1'b0;
    end else begin
      state       <= state_n;
      start_pend  <= start_pend_n;
      done        <= done_n;
      proc_enable <= (state_n == RUN) || (state_n == P_ACC);
    end
  end

  mem_access_engine #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .MEM_LAT(MEM_LAT)
  ) u_eng (
    .clk       (clk),
    .rst       (rst),
    .start     (go),
    .src       (go_src),
    .we        (go_we),
    .addr      (go_addr),
    .wdata     (go_wdata),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .host_ack  (host_ack),
    .host_rdata(host_rdata),
    .proc_ack  (proc_ack),
    .proc_rdata(proc_rdata)
  );

endmodule

// File: doc/mem_sched.md
# mem_sched

System sequencer and data-memory arbiter for the downsampling processor. Owns the shared 8-bit data DRAM: the host port (image loader / result reader) has it while the processor is idle. A host start pulse hands the DRAM exclusively to the processor, and processor `finish` returns it. It also drives the processor `enable` and serialises every DRAM access through a fixed-latency access engine.

## Interface
- `ADDR_W`, 16, DRAM address width
- `DATA_W`, 8, DRAM data width
- `MEM_LAT`, 2, DRAM read latency in cycles after the `mem_en` cycle (≥1)

Ports:
- `clk` in 1: single system clock, rising edge
- `rst` in 1: asynchronous, active-high reset
- `host_start` in 1: one-cycle pulse; launches a processor run
- `host_req` in 1: host access request; held until `host_ack`
- `host_we` in 1: 1 = write, 0 = read
- `host_addr` in ADDR_W: host address
- `host_wdata` in DATA_W: host write data
- `host_ack` out 1: one-cycle completion pulse
- `host_rdata` out DATA_W: read data, valid with `host_ack`, then held
- `done` out 1: sticky; set on run completion, cleared by the next accepted start
- `proc_enable` out 1: processor run enable
- `proc_finish` in 1: processor finish flag
- `proc_read` in 1, `proc_write` in 1: processor access strobes; held until `proc_ack`
- `proc_addr` in ADDR_W, `proc_wdata` in DATA_W: processor address and write data
- `proc_ack` out 1: one-cycle completion pulse
- `proc_rdata` out DATA_W: read data, valid with `proc_ack`, then held
- `mem_en` out 1, `mem_we` out 1: DRAM strobe and write enable
- `mem_addr` out ADDR_W, `mem_wdata` out DATA_W: DRAM address and write data
- `mem_rdata` in DATA_W: DRAM read data

## Operation
- States:
  - IDLE: host owns the DRAM.
  - H_ACC: host access in flight.
  - RUN: processor enabled, no access in flight.
  - P_ACC: processor access in flight.
- IDLE transitions:
  - `host_req` → H_ACC.
  - `host_start` without `host_req` → RUN: clear `done`, set `proc_enable`.
  - `host_start` and `host_req` in the same cycle: the access is served first. The start is latched in `start_pend`, and H_ACC exits to RUN instead of IDLE.
- `host_start` outside IDLE and not already pending is ignored.
- RUN transitions:
  - `proc_finish` → IDLE: drop `proc_enable`, set `done`.
  - Else `proc_read|proc_write` → P_ACC.
  - `proc_finish` wins over a same-cycle strobe; that access is discarded.
- P_ACC returns to RUN after `proc_ack`. `proc_finish` raised during P_ACC is acted on only after the access completes.
- While in RUN or P_ACC, `host_req` is never acked and host outputs hold their values.
- If `proc_read` and `proc_write` are both high, the access is a write.
- Access engine:
  - Latches addr, wdata and we on entry.
  - Pulses `mem_en` for exactly one cycle.
  - A counter of width clog2(MEM_LAT+1) counts MEM_LAT cycles.
  - Captures `mem_rdata` into the requester's rdata register and pulses that requester's ack.
  - Writes use the same timing. Their rdata registers are unchanged.
- After an ack, a request still high on the next cycle is a new request.
- `proc_enable` is high in RUN and P_ACC only.

## Timing
- Reset values:
  - state = IDLE
  - all outputs 0, including `proc_enable`, `done`, both rdata registers and `mem_*`
  - `start_pend` = 0
  - counter = 0
- Reset mid-access aborts the access with no ack. `mem_en` drops asynchronously.
- All outputs are registered.
- Latency for a request sampled at edge k:
  - `mem_en` is high during cycle k+1.
  - `mem_rdata` is sampled at edge k+1+MEM_LAT.
  - The ack is high during cycle k+2+MEM_LAT.
- Access throughput: one access per MEM_LAT+3 cycles.
- Start sampled at edge k: `proc_enable` is high from cycle k+1.
- Finish sampled at edge k: `proc_enable` is low and `done` is high from cycle k+1.
- Address and data registers are ADDR_W and DATA_W wide. No arithmetic is done on them.

## Structure
- Package `mem_sched_pkg` holds:
  - the state encoding (IDLE=0, H_ACC=1, RUN=2, P_ACC=3)
  - default widths
  - the MEM_LAT default
- One natural sub-module, `mem_access_engine`: latch, `mem_en` pulse, latency counter, rdata capture and ack generation.
- The top level holds the ownership FSM, `start_pend` and `done`.

## Test plan
- Reset then host write: `host_req`, `host_we`=1, addr 0x0010, data 0xA5 → `mem_en` one cycle with `mem_we`=1 and addr 0x0010, data 0xA5; `host_ack` 4 cycles later (MEM_LAT=2).
- Host read of 0x0010 with the DRAM model returning 0xA5 → `host_rdata`=0xA5 with `host_ack`, held afterwards.
- `host_start` → `proc_enable` next cycle. A `proc_read` at 0x0020 acks with data. `host_req` raised during the run receives no ack.
- Simultaneous `proc_finish` and `proc_write` in RUN → no `mem_en`; `proc_enable`=0 and `done`=1 next cycle.
- Same-cycle `host_start` and `host_req` → the host access completes first; `proc_enable` rises the cycle after `host_ack`.
- `rst` asserted during P_ACC → all outputs 0 immediately, no ack, state IDLE.
